// File: rtl/console_pkg.sv
// Console: shared state encodings and frame constants.
// Imported by the serializer and the bus wrapper.
package console_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/console_uart_tx.sv
// Console: 8N1 serializer, LSB first, CLKS_PER_BIT clocks per bit.
// busy is high from the cycle after start until the stop bit ends.
module console_uart_tx
  import console_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_CLK =
    CW'(CLKS_PER_BIT - 1);
  // start and stop bits bracket the data bits
  localparam logic [2:0] LAST_IDX =
    3'(FRAME_BITS - 3);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (cnt == LAST_CLK);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_START;
            shreg <= data;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            idx <= idx + 3'd1;
            if (idx == LAST_IDX)
              state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (1'b1)
      (state == ST_START): tx = 1'b0;
      (state == ST_DATA):  tx = shreg[idx];
      default:             tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/console.sv
// Console: write-only bus port feeding a UART transmitter.
// One-cycle ack per accepted byte; stalls while a frame is on the line.
module console
  import console_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit SIM_PRINT    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_stb,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_tx
);

  logic busy;
  logic accept;
  logic unused_hi;

  // reset wins over a coincident strobe
  assign accept     = i_wb_stb & ~busy & ~i_reset;
  assign o_wb_stall = busy;
  assign unused_hi  = ^i_wb_data[31:8];

  console_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (i_clk),
    .reset(i_reset),
    .start(accept),
    .data (i_wb_data[7:0]),
    .tx   (o_tx),
    .busy (busy)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_wb_ack <= 1'b0;
    else
      o_wb_ack <= accept;
  end

`ifndef SYNTHESIS
  if (SIM_PRINT) begin : g_print
    always_ff @(posedge i_clk) begin
      if (accept)
        $write("%c", i_wb_data[7:0]);
    end
  end
`endif

endmodule

// File: tb/tb_console.sv
// Console bench: bus driver, serial-line decoder and byte scoreboard.
// Checks handshake timing, frame shape, stall masking and reset abort.
module tb_console;
  import console_pkg::*;

  localparam int CPB = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        stb   = 1'b0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic        stall;
  logic        tx;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  bit          mon_off = 1'b0;
  logic [7:0]  mon_got;
  logic [7:0]  mon_exp;
  logic [39:0] trace;
  logic [9:0]  a_seq;

  console #(
    .CLKS_PER_BIT(CPB),
    .SIM_PRINT   (1)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wb_stb  (stb),
    .i_wb_data (wdata),
    .o_wb_ack  (ack),
    .o_wb_stall(stall),
    .o_tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic send(
    input  logic [31:0] d,
    input  bit          push,
    input  bit          poke,
    output logic [39:0] tr
  );
    int n;
    int hi;
    int acks;
    n    = 0;
    hi   = 0;
    acks = 0;
    while (stall !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(n < 100), 32'd1);
    stb   = 1'b1;
    wdata = d;
    @(negedge clk);
    stb   = 1'b0;
    wdata = $urandom;
    check("ack", 32'(ack), 32'd1);
    if (push) exp_q.push_back(d[7:0]);
    for (int k = 0; k < 40; k++) begin
      if (k > 0 && ack === 1'b1) acks++;
      if (stall === 1'b1) hi++;
      tr[k] = tx;
      stb   = poke && (k % 10 == 5);
      wdata = 32'h0000_0055;
      @(negedge clk);
    end
    stb = 1'b0;
    check("stall_cycles", hi, 40);
    check("extra_ack", acks, 0);
    check("ack_end", 32'(ack), 32'd0);
    check("stall_end", 32'(stall), 32'd0);
  endtask

  // serial-line decoder: mid-bit sampling, compares against scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_off && reset === 1'b0 && tx === 1'b0) begin
        repeat (2) @(negedge clk);
        check("start_bit", 32'(tx), 32'd0);
        repeat (3) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          mon_got[b] = tx;
          repeat (4) @(negedge clk);
        end
        check("stop_bit", 32'(tx), 32'd1);
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("frame_byte", 32'(mon_got), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int lows;
    int acks;
    logic [7:0] r;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_ack", 32'(ack), 32'd0);
    end

    // 'A' line shape, bit order start..stop
    a_seq = 10'b10_1000_0010;
    send(32'h0000_0041, 1'b1, 1'b0, trace);
    for (int b = 0; b < 10; b++)
      check($sformatf("A_bit%0d", b),
            32'(trace[4*b +: 4]), {28'd0, {4{a_seq[b]}}});

    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom_range(32, 126));
      send({$urandom, r} & 32'hFFFF_FFFF,
           1'b1, 1'b0, trace);
    end

    send(32'h0000_0042, 1'b1, 1'b1, trace);
    send(32'hFFFF_FF7E, 1'b1, 1'b0, trace);

    // abort a frame with reset, strobe held at the reset edge
    mon_off = 1'b1;
    stb     = 1'b1;
    wdata   = 32'h0000_0058;
    @(negedge clk);
    stb = 1'b0;
    check("abort_ack", 32'(ack), 32'd1);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    stb   = 1'b1;
    wdata = 32'h0000_0059;
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_ack0", 32'(ack), 32'd0);
    check("abort_state", 32'(dut.u_tx.state),
          32'(ST_IDLE));
    reset = 1'b0;
    stb   = 1'b0;
    lows  = 0;
    acks  = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (ack !== 1'b0) acks++;
    end
    check("no_retx", lows, 0);
    check("no_ack_after_rst", acks, 0);
    mon_off = 1'b0;

    send(32'h0000_0043, 1'b1, 1'b0, trace);

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/console.md
CONSOLE -- requirements
Module: console

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (legal range 1 to 65535).
REQ-002 SHALL have parameter SIM_PRINT, default 1, meaning that when 1, each accepted character is also written to the simulator console (non-synthesizable, guarded).
REQ-003 SHALL have port i_clk, input, width 1: clock clk, all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, width 1: reset reset, synchronous, active-high.
REQ-005 SHALL have port i_wb_stb, input, width 1: write strobe, one-cycle request.
REQ-006 SHALL have port i_wb_data, input, width 32: write data; only bits [7:0] are used (ASCII character).
REQ-007 SHALL have port o_wb_ack, output, width 1: one-cycle acknowledge of an accepted write.
REQ-008 SHALL have port o_wb_stall, output, width 1: high while unable to accept a write.
REQ-009 SHALL have port o_tx, output, width 1: UART 8N1 serial line, idle high.

Function
REQ-010 SHALL accept a write on a rising edge where i_wb_stb=1 and o_wb_stall=0; bits [31:8] are ignored.
REQ-011 SHALL ignore i_wb_stb while o_wb_stall=1: no ack, no transmission, no effect on the frame in progress.
REQ-012 SHALL assert o_wb_ack for exactly one cycle, in the cycle immediately following acceptance, and never otherwise.
REQ-013 SHALL NOT require i_wb_stb to be held beyond the accept cycle.
REQ-014 SHALL drive o_wb_stall=1 from the cycle after acceptance until the stop bit completes, and 0 in IDLE.
REQ-015 SHALL implement states IDLE, START, DATA, STOP.
REQ-016 On acceptance the block SHALL go IDLE->START, latching the byte.
REQ-017 START SHALL drive o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-018 DATA SHALL drive bits 0..7, LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
REQ-019 STOP SHALL drive o_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-020 One frame SHALL take 10*CLKS_PER_BIT cycles, with the next accept possible on the first IDLE cycle.
REQ-021 SHALL use a bit-cycle counter of ceil(log2(CLKS_PER_BIT+1)) bits and a bit index of 3 bits; neither may wrap mid-bit.
REQ-022 When SIM_PRINT=1, the block SHALL print the accepted byte as a character, without a newline, in the accept cycle.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately; the aborted byte SHALL NOT be retransmitted.

Reset
REQ-024 On reset the block SHALL set state=IDLE, o_tx=1, o_wb_ack=0, o_wb_stall=0, and clear the counters and the data latch.
REQ-025 A strobe coincident with asserted reset SHALL be ignored.
REQ-026 Reset priority: reset SHALL override all other events in the same cycle.

Structure
REQ-027 Package console_pkg SHALL hold the state encodings (IDLE=0, START=1, DATA=2, STOP=3) and the frame length constant of 10 bits.
REQ-028 The serializer SHALL be one sub-module, console_uart_tx, with inputs start and data[7:0] and outputs tx and busy.
REQ-029 console SHALL wrap console_uart_tx, adding the bus handshake, the ack register and the simulation print.

Verification
REQ-030 Reset 2 cycles, then idle -> o_tx=1, o_wb_stall=0, o_wb_ack=0 on every cycle.
REQ-031 One-cycle stb with data 0x00000041 -> ack exactly 1 cycle later, stall high for 40 cycles (CLKS_PER_BIT=4), o_tx sequence 0,1,0,0,0,0,0,1,0,1 with each bit lasting 4 cycles, and "A" printed.
REQ-032 Repeated single-cycle strobes of random values 32-126, each issued after stall falls -> one ack per strobe, frames back-to-back, LSB-first data matches.
REQ-033 stb pulsed while stall=1 during a frame for 0x42 -> no ack, frame unchanged.
REQ-034 Data 0xFFFFFF7E -> transmits 0x7E only.
REQ-035 Reset asserted at cycle 15 of a frame -> o_tx=1, stall=0, state IDLE the next cycle; a new write of 0x43 is then accepted normally.
